// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count_monitor checker and its step predictor.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int CNT_W   = 3;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Top value of a counter of width w.
  function automatic int top_of(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/count_monitor_if.sv
// Observation bus between the bouncing counter (master side) and count_monitor (slave side).
interface count_monitor_if #(
  parameter int W       = 3,
  parameter int SWEEP_W = 8
);
  logic               enable;
  logic [W-1:0]       q;
  logic               dir;
  logic               at_top;
  logic               at_bot;
  logic               fault;
  logic               err;
  logic [SWEEP_W-1:0] sweeps;

  modport master (
    output enable, q,
    input  dir, at_top, at_bot, fault, err, sweeps
  );

  modport slave (
    input  enable, q,
    output dir, at_top, at_bot, fault, err, sweeps
  );
endinterface

// File: rtl/count_monitor_step_predict.sv
// Combinational prediction of the next legal counter value from the previous sample,
// the tracked direction and the delayed enable.
module count_monitor_step_predict
  import count_monitor_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] q_prev_i,
  input  state_e       state_i,
  input  logic         en_d_i,
  output logic [W-1:0] exp_o,
  output logic         turn_top_o,
  output logic         turn_bot_o,
  output logic         step_taken_o
);

  localparam logic [W-1:0] TOP = W'(top_of(W));

  always_comb begin
    exp_o        = q_prev_i;
    turn_top_o   = 1'b0;
    turn_bot_o   = 1'b0;
    step_taken_o = en_d_i && (state_i != FAULT);
    if (step_taken_o) begin
      case (state_i)
        UP: begin
          if (q_prev_i == TOP) begin
            exp_o      = TOP - 1'b1;
            turn_top_o = 1'b1;
          end else begin
            exp_o = q_prev_i + 1'b1;
          end
        end
        DOWN: begin
          if (q_prev_i == '0) begin
            exp_o      = W'(1);
            turn_bot_o = 1'b1;
          end else begin
            exp_o = q_prev_i - 1'b1;
          end
        end
        default: exp_o = q_prev_i;
      endcase
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Passive checker for a bouncing up/down counter: tracks direction, flags turns, counts round trips.
// Define MONITOR_SWEEP_EN to build the saturating round-trip counter; otherwise sweeps reads 0.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int W       = 3,
  parameter int SWEEP_W = 8
) (
  input  logic            clock,
  input  logic            clear,
  count_monitor_if.slave  mon
);

  logic [W-1:0] q_prev_q;
  logic         en_d_q;
  state_e       state_q, state_d;
  logic         dir_q, dir_d;
  logic         at_top_q, at_top_d;
  logic         at_bot_q, at_bot_d;
  logic         err_q, err_d;
  logic         sweep_inc;

  logic [W-1:0] exp_val;
  logic         turn_top, turn_bot, step_taken;

  count_monitor_step_predict #(.W(W)) u_predict (
    .q_prev_i     (q_prev_q),
    .state_i      (state_q),
    .en_d_i       (en_d_q),
    .exp_o        (exp_val),
    .turn_top_o   (turn_top),
    .turn_bot_o   (turn_bot),
    .step_taken_o (step_taken)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    at_top_d  = 1'b0;
    at_bot_d  = 1'b0;
    err_d     = err_q;
    sweep_inc = 1'b0;
    case (state_q)
      // Resync only on a clean zero sample; the counter restarts upward from there.
      FAULT: begin
        if (mon.q == '0) state_d = UP;
      end
      default: begin
        if (mon.q != exp_val) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else if (turn_top) begin
          state_d  = DOWN;
          at_top_d = 1'b1;
        end else if (turn_bot) begin
          state_d = UP;
        end else if (state_q == DOWN && step_taken && q_prev_q == W'(1) && mon.q == '0) begin
          at_bot_d  = 1'b1;
          sweep_inc = 1'b1;
        end
      end
    endcase
    case (state_d)
      UP:      dir_d = DIR_UP;
      DOWN:    dir_d = DIR_DN;
      default: dir_d = dir_q;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_prev_q <= '0;
      en_d_q   <= 1'b0;
      state_q  <= UP;
      dir_q    <= DIR_UP;
      at_top_q <= 1'b0;
      at_bot_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      q_prev_q <= mon.q;
      en_d_q   <= mon.enable;
      state_q  <= state_d;
      dir_q    <= dir_d;
      at_top_q <= at_top_d;
      at_bot_q <= at_bot_d;
      err_q    <= err_d;
    end
  end

`ifdef MONITOR_SWEEP_EN
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;

  always_comb begin
    sweeps_d = sweeps_q;
    if (sweep_inc && sweeps_q != {SWEEP_W{1'b1}}) sweeps_d = sweeps_q + 1'b1;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) sweeps_q <= '0;
    else       sweeps_q <= sweeps_d;
  end

  assign mon.sweeps = sweeps_q;
`else
  logic sweep_inc_unused;
  assign sweep_inc_unused = sweep_inc;
  assign mon.sweeps       = {SWEEP_W{1'b0}};
`endif

  assign mon.dir    = dir_q;
  assign mon.at_top = at_top_q;
  assign mon.at_bot = at_bot_q;
  assign mon.fault  = (state_q == FAULT);
  assign mon.err    = err_q;

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: a behavioural model predicts each edge's outputs,
// which are queued when inputs are driven and compared once the edge has happened.
module tb_count_monitor;

`ifdef MONITOR_SWEEP_EN
  localparam bit SW_ON = 1'b1;
`else
  localparam bit SW_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear;

  count_monitor_if #(.W(3), .SWEEP_W(2)) mon_if ();

  count_monitor #(.W(3), .SWEEP_W(2)) dut (
    .clock (clock),
    .clear (clear),
    .mon   (mon_if.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       dir;
    logic       at_top;
    logic       at_bot;
    logic       fault;
    logic       err;
    logic [1:0] sweeps;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   top_cnt  = 0;
  int   bot_cnt  = 0;

  // Model state: 0 = up, 1 = down, 2 = fault.
  logic [2:0] m_qprev;
  logic       m_en;
  int         m_state;
  logic       m_dir;
  logic       m_err;
  logic [1:0] m_sw;

  // Legal bouncing counter used to generate stimulus.
  logic [2:0] ctr;
  logic       cup;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_qprev = 3'd0;
    m_en    = 1'b0;
    m_state = 0;
    m_dir   = 1'b1;
    m_err   = 1'b0;
    m_sw    = 2'd0;
  endtask

  task automatic model_edge(input logic [2:0] qv, input logic en, output exp_t e);
    logic tp;
    logic bt;
    int   ex;
    tp = 1'b0;
    bt = 1'b0;
    if (m_state == 2) begin
      if (qv == 3'd0) m_state = 0;
    end else begin
      if (!m_en)              ex = int'(m_qprev);
      else if (m_state == 0)  ex = (m_qprev == 3'd7) ? 6 : int'(m_qprev) + 1;
      else                    ex = (m_qprev == 3'd0) ? 1 : int'(m_qprev) - 1;
      if (int'(qv) != ex) begin
        m_state = 2;
        m_err   = 1'b1;
      end else if (m_en && m_state == 0 && m_qprev == 3'd7) begin
        m_state = 1;
        tp      = 1'b1;
      end else if (m_en && m_state == 1 && m_qprev == 3'd0) begin
        m_state = 0;
      end else if (m_en && m_state == 1 && m_qprev == 3'd1) begin
        bt = 1'b1;
        if (SW_ON && m_sw != 2'd3) m_sw = m_sw + 2'd1;
      end
    end
    if (m_state == 0)      m_dir = 1'b1;
    else if (m_state == 1) m_dir = 1'b0;
    m_qprev  = qv;
    m_en     = en;
    e.dir    = m_dir;
    e.at_top = tp;
    e.at_bot = bt;
    e.fault  = (m_state == 2);
    e.err    = m_err;
    e.sweeps = m_sw;
  endtask

  // Drive one sample, let one edge pass, then compare against the queued expectation.
  task automatic cycle(input logic en, input logic [2:0] qv);
    exp_t e;
    mon_if.enable = en;
    mon_if.q      = qv;
    model_edge(qv, en, e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      $display("txn q=%0d en=%0d dir=%0d top=%0d bot=%0d fault=%0d err=%0d sweeps=%0d",
               qv, en, mon_if.dir, mon_if.at_top, mon_if.at_bot, mon_if.fault, mon_if.err, mon_if.sweeps);
      check("dir",    mon_if.dir,    e.dir);
      check("at_top", mon_if.at_top, e.at_top);
      check("at_bot", mon_if.at_bot, e.at_bot);
      check("fault",  mon_if.fault,  e.fault);
      check("err",    mon_if.err,    e.err);
      check("sweeps", mon_if.sweeps, e.sweeps);
    end
    if (mon_if.at_top === 1'b1) top_cnt++;
    if (mon_if.at_bot === 1'b1) bot_cnt++;
  endtask

  task automatic step_ctr();
    if (cup) begin
      if (ctr == 3'd7) begin cup = 1'b0; ctr = 3'd6; end
      else ctr = ctr + 3'd1;
    end else begin
      if (ctr == 3'd0) begin cup = 1'b1; ctr = 3'd1; end
      else ctr = ctr - 3'd1;
    end
  endtask

  task automatic legal(input int n, input logic en);
    repeat (n) begin
      cycle(en, ctr);
      if (en) step_ctr();
    end
  endtask

  // Asserts clear between edges and checks reset values before any edge arrives.
  task automatic clear_pulse(input string tag);
    @(negedge clock);
    clear = 1'b1;
    #1;
    sb_q.delete();
    model_reset();
    check({tag, "_dir"},    mon_if.dir,    32'd1);
    check({tag, "_at_top"}, mon_if.at_top, 32'd0);
    check({tag, "_at_bot"}, mon_if.at_bot, 32'd0);
    check({tag, "_fault"},  mon_if.fault,  32'd0);
    check({tag, "_err"},    mon_if.err,    32'd0);
    check({tag, "_sweeps"}, mon_if.sweeps, 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    ctr = 3'd0;
    cup = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear         = 1'b0;
    mon_if.enable = 1'b0;
    mon_if.q      = 3'd0;
    @(posedge clock);
    #1;
    clear_pulse("reset");

    // Full legal round trip 0..7..0.
    top_cnt = 0; bot_cnt = 0;
    legal(15, 1'b1);
    check("t1_top_pulses", top_cnt, 32'd1);
    check("t1_bot_pulses", bot_cnt, 32'd1);
    check("t1_err",        mon_if.err, 32'd0);
    check("t1_sweeps",     mon_if.sweeps, SW_ON ? 32'd1 : 32'd0);

    // Climb to 3 and hold with enable low.
    legal(2, 1'b1);
    top_cnt = 0; bot_cnt = 0;
    legal(5, 1'b0);
    check("t2_pulses", top_cnt + bot_cnt, 32'd0);
    check("t2_dir",    mon_if.dir, 32'd1);
    check("t2_err",    mon_if.err, 32'd0);

    // Skip 5 while counting up, then resync on zero.
    legal(2, 1'b1);
    cycle(1'b1, 3'd6);
    check("t3_fault", mon_if.fault, 32'd1);
    check("t3_err",   mon_if.err,   32'd1);
    cycle(1'b1, 3'd0);
    ctr = 3'd1; cup = 1'b1;
    legal(4, 1'b1);
    check("t3_fault_after", mon_if.fault, 32'd0);
    check("t3_err_sticky",  mon_if.err,   32'd1);
    check("t3_dir",         mon_if.dir,   32'd1);

    // Illegal wrap 7 -> 0 while up: fault, no turn pulse, resync on the next zero.
    legal(3, 1'b1);
    top_cnt = 0;
    cycle(1'b1, 3'd0);
    check("t4_fault",  mon_if.fault, 32'd1);
    check("t4_err",    mon_if.err,   32'd1);
    check("t4_no_top", top_cnt,      32'd0);
    cycle(1'b1, 3'd0);
    check("t4_resync", mon_if.fault, 32'd0);

    // Five round trips against the 2-bit saturating sweep counter.
    clear_pulse("clr5");
    top_cnt = 0; bot_cnt = 0;
    repeat (5) legal(14, 1'b1);
    legal(1, 1'b1);
    check("t5_bot_pulses", bot_cnt, 32'd5);
    check("t5_top_pulses", top_cnt, 32'd5);
    check("t5_sweeps",     mon_if.sweeps, SW_ON ? 32'd3 : 32'd0);

    // Error partway down, then asynchronous clear, then a clean restart.
    legal(10, 1'b1);
    cycle(1'b1, 3'd2);
    check("t6_err_set", mon_if.err, 32'd1);
    clear_pulse("clr6");
    legal(3, 1'b1);
    check("t6_err",   mon_if.err,   32'd0);
    check("t6_fault", mon_if.fault, 32'd0);
    check("t6_dir",   mon_if.dir,   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
